// File: rtl/os_mac_array.sv
// rtl/os_mac_array.sv - output-stationary MAC array; define OS_MAC_ARRAY_SATURATE_EN for saturating accumulators
module os_mac_array #(
   parameter int BW      = 4,
   parameter int PSUM_BW = 16,
   parameter int ROWS    = 8,
   parameter int COLS    = 8,
   parameter int KW      = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [KW-1:0]             k_len,
   input  logic                      act_2b_mode,
   input  logic [ROWS*BW-1:0]        in_w,
   input  logic [COLS*BW-1:0]        in_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [COLS*PSUM_BW-1:0]   out_data,
   output logic [$clog2(ROWS)-1:0]   out_row,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      busy,
   output logic                      done
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOAD   = 2'd1;
   localparam logic [1:0] SETTLE = 2'd2;
   localparam logic [1:0] DRAIN  = 2'd3;

   localparam int RW = $clog2(ROWS);
   localparam int SW = $clog2(ROWS + COLS);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(ROWS + COLS - 1);
   localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);

   logic [1:0]    state;
   logic [KW-1:0] k_lat;
   logic [KW-1:0] step_cnt;
   logic          mode_2b;
   logic [SW-1:0] settle_cnt;
   logic [RW-1:0] row_q;
   logic          done_q;
   logic          accept;
   logic          clr;
   logic [BW-1:0] act_mask;

   logic [BW-1:0]      lane_a [ROWS];
   logic [BW-1:0]      lane_w [COLS];
   logic [BW-1:0]      sk_a   [ROWS][ROWS];
   logic               sk_av  [ROWS][ROWS];
   logic [BW-1:0]      sk_w   [COLS][COLS];
   logic               sk_wv  [COLS][COLS];
   logic [BW-1:0]      a_in   [ROWS][COLS];
   logic [BW-1:0]      w_in   [ROWS][COLS];
   logic               av_in  [ROWS][COLS];
   logic               wv_in  [ROWS][COLS];
   logic [BW-1:0]      a_q    [ROWS][COLS];
   logic [BW-1:0]      w_q    [ROWS][COLS];
   logic               av_q   [ROWS][COLS];
   logic               wv_q   [ROWS][COLS];
   logic [PSUM_BW-1:0] acc    [ROWS][COLS];

   assign in_ready  = (state == LOAD);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DRAIN);
   assign out_row   = row_q;
   assign done      = done_q;
   assign accept    = in_ready & in_valid;
   assign clr       = (state == IDLE) & start;
   assign act_mask  = mode_2b ? BW'(3) : '1;

`ifdef OS_MAC_ARRAY_SATURATE_EN
   // One extra bit exposes overflow; products are small so sum never exceeds PSUM_BW+1 bits.
   function automatic logic [PSUM_BW-1:0] mac(input logic [PSUM_BW-1:0] a_acc,
                                              input logic [BW-1:0] a, input logic [BW-1:0] w);
      logic [PSUM_BW:0] ae, we, sum;
      ae  = {{(PSUM_BW+1-BW){1'b0}}, a};
      we  = {{(PSUM_BW+1-BW){w[BW-1]}}, w};
      sum = {a_acc[PSUM_BW-1], a_acc} + ae * we;
      if (sum[PSUM_BW] != sum[PSUM_BW-1])
         mac = sum[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
      else
         mac = sum[PSUM_BW-1:0];
   endfunction
`else
   // Modular arithmetic: unsigned multiply of extended operands gives the two's-complement result.
   function automatic logic [PSUM_BW-1:0] mac(input logic [PSUM_BW-1:0] a_acc,
                                              input logic [BW-1:0] a, input logic [BW-1:0] w);
      logic [PSUM_BW-1:0] ae, we;
      ae  = {{(PSUM_BW-BW){1'b0}}, a};
      we  = {{(PSUM_BW-BW){w[BW-1]}}, w};
      mac = a_acc + ae * we;
   endfunction
`endif

   // Tile control: latch config on start, count steps, settle, then drain rows
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         k_lat      <= '0;
         step_cnt   <= '0;
         mode_2b    <= 1'b0;
         settle_cnt <= '0;
         row_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: if (start) begin
               k_lat      <= k_len;
               mode_2b    <= act_2b_mode;
               step_cnt   <= '0;
               settle_cnt <= '0;
               state      <= (k_len == '0) ? SETTLE : LOAD;
            end
            LOAD: if (accept) begin
               if (step_cnt + KW'(1) == k_lat) state <= SETTLE;
               step_cnt <= step_cnt + KW'(1);
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state <= DRAIN;
                  row_q <= '0;
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            DRAIN: if (out_ready) begin
               if (row_q == ROW_LAST) begin
                  state  <= IDLE;
                  row_q  <= '0;
                  done_q <= 1'b1;
               end else begin
                  row_q <= row_q + RW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Split the input buses into lanes, masking activations in 2-bit mode
   always_comb begin
      for (int r = 0; r < ROWS; r++) lane_a[r] = in_w[r*BW +: BW] & act_mask;
      for (int c = 0; c < COLS; c++) lane_w[c] = in_n[c*BW +: BW];
   end

   // Skew chains: lane i is delayed i cycles so operands meet in the right PE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < ROWS; r++)
            for (int s = 0; s < ROWS; s++) begin
               sk_a[r][s]  <= '0;
               sk_av[r][s] <= 1'b0;
            end
         for (int c = 0; c < COLS; c++)
            for (int s = 0; s < COLS; s++) begin
               sk_w[c][s]  <= '0;
               sk_wv[c][s] <= 1'b0;
            end
      end else begin
         for (int r = 0; r < ROWS; r++)
            for (int s = 0; s < ROWS; s++) begin
               sk_a[r][s]  <= (s == 0) ? lane_a[r] : sk_a[r][(s > 0) ? s-1 : 0];
               sk_av[r][s] <= (s == 0) ? accept    : sk_av[r][(s > 0) ? s-1 : 0];
            end
         for (int c = 0; c < COLS; c++)
            for (int s = 0; s < COLS; s++) begin
               sk_w[c][s]  <= (s == 0) ? lane_w[c] : sk_w[c][(s > 0) ? s-1 : 0];
               sk_wv[c][s] <= (s == 0) ? accept    : sk_wv[c][(s > 0) ? s-1 : 0];
            end
      end
   end

   // Operand arriving at each PE: from the skew chain on the edge, else from the neighbour
   always_comb begin
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            if (c == 0) begin
               a_in[r][c]  = (r == 0) ? lane_a[r] : sk_a[r][(r > 0) ? r-1 : 0];
               av_in[r][c] = (r == 0) ? accept    : sk_av[r][(r > 0) ? r-1 : 0];
            end else begin
               a_in[r][c]  = a_q[r][(c > 0) ? c-1 : 0];
               av_in[r][c] = av_q[r][(c > 0) ? c-1 : 0];
            end
            if (r == 0) begin
               w_in[r][c]  = (c == 0) ? lane_w[c] : sk_w[c][(c > 0) ? c-1 : 0];
               wv_in[r][c] = (c == 0) ? accept    : sk_wv[c][(c > 0) ? c-1 : 0];
            end else begin
               w_in[r][c]  = w_q[(r > 0) ? r-1 : 0][c];
               wv_in[r][c] = wv_q[(r > 0) ? r-1 : 0][c];
            end
         end
   end

   // PE grid: forward operands east/south and accumulate when both are valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
               a_q[r][c]  <= '0;
               w_q[r][c]  <= '0;
               av_q[r][c] <= 1'b0;
               wv_q[r][c] <= 1'b0;
               acc[r][c]  <= '0;
            end
      end else begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
               a_q[r][c]  <= a_in[r][c];
               w_q[r][c]  <= w_in[r][c];
               av_q[r][c] <= av_in[r][c];
               wv_q[r][c] <= wv_in[r][c];
               if (clr)
                  acc[r][c] <= '0;
               else if (av_in[r][c] && wv_in[r][c])
                  acc[r][c] <= mac(acc[r][c], a_in[r][c], w_in[r][c]);
            end
      end
   end

   // Present the selected row of accumulators
   always_comb begin
      out_data = '0;
      for (int c = 0; c < COLS; c++) out_data[c*PSUM_BW +: PSUM_BW] = acc[row_q][c];
   end

endmodule

// File: tb/tb_os_mac_array.sv
// tb/tb_os_mac_array.sv - directed bench for os_mac_array (4x4, BW=4, PSUM_BW=16)
module tb_os_mac_array;

   localparam int BW      = 4;
   localparam int PSUM_BW = 16;
   localparam int ROWS    = 4;
   localparam int COLS    = 4;
   localparam int KW      = 10;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    start;
   logic [KW-1:0]           k_len;
   logic                    act_2b_mode;
   logic [ROWS*BW-1:0]      in_w;
   logic [COLS*BW-1:0]      in_n;
   logic                    in_valid;
   logic                    in_ready;
   logic [COLS*PSUM_BW-1:0] out_data;
   logic [1:0]              out_row;
   logic                    out_valid;
   logic                    out_ready;
   logic                    busy;
   logic                    done;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] exp_m [ROWS][COLS];

   os_mac_array #(.BW(BW), .PSUM_BW(PSUM_BW), .ROWS(ROWS), .COLS(COLS), .KW(KW)) dut (
      .clk(clk), .reset(reset), .start(start), .k_len(k_len), .act_2b_mode(act_2b_mode),
      .in_w(in_w), .in_n(in_n), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [63:0] exp_row(input int r);
      logic [63:0] v;
      v = '0;
      for (int c = 0; c < COLS; c++) v[c*16 +: 16] = exp_m[r][c];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_tile(input int k, input logic mode, input logic [15:0] wv, input logic [15:0] nv,
                           input bit gap, input bit stall, input bit poke, input int abort_row);
      int acc_n;
      int cyc;
      int w;
      logic rdy;
      start = 1'b1; k_len = KW'(k); act_2b_mode = mode;
      tick();
      start = 1'b0; k_len = '0; act_2b_mode = 1'b0;
      check("load_ready", in_ready, (k != 0));
      check("busy_after_start", busy, 1);
      acc_n = 0; cyc = 0;
      while (acc_n < k && cyc < 2000) begin
         in_valid = !(gap && (cyc % 2 == 1));
         in_w = wv; in_n = nv;
         rdy = in_ready;
         tick();
         if (in_valid && rdy) acc_n++;
         cyc++;
      end
      check("steps_accepted", acc_n, k);
      in_valid = poke;
      start = poke;
      w = 0;
      while (!out_valid && w < 50) begin
         tick();
         w++;
      end
      start = 1'b0; in_valid = 1'b0;
      check("settle_len", w, ROWS + COLS);
      for (int r = 0; r < ROWS; r++) begin
         out_ready = 1'b1;
         if (r == abort_row) begin
            reset = 1'b1;
            tick();
            check("abort_out_valid", out_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_out_data", out_data, 0);
            reset = 1'b0;
            out_ready = 1'b0;
            tick();
            check("abort_no_done", done, 0);
            return;
         end
         check("drain_valid", out_valid, 1);
         check("drain_row", out_row, r);
         check("drain_data", out_data, exp_row(r));
         check("drain_no_done", done, 0);
         if (stall && r == 1) begin
            out_ready = 1'b0;
            repeat (5) begin
               tick();
               check("stall_row", out_row, 1);
               check("stall_data", out_data, exp_row(1));
               check("stall_valid", out_valid, 1);
            end
            out_ready = 1'b1;
         end
         tick();
      end
      out_ready = 1'b0;
      check("done_pulse", done, 1);
      check("idle_busy", busy, 0);
      check("idle_out_valid", out_valid, 0);
      tick();
      check("done_once", done, 0);
      check("acc_hold", out_data, exp_row(0));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; k_len = '0; act_2b_mode = 1'b0;
      in_w = '0; in_n = '0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_row", out_row, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b0;
      tick();

      // k=1, all ones
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) exp_m[r][c] = 16'd1;
      run_tile(1, 1'b0, 16'h1111, 16'h1111, 1'b0, 1'b0, 1'b0, -1);

      // k=3, act r+1, weight c-2, with input gaps and an output stall at row 1
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) exp_m[r][c] = 16'(3 * (r + 1) * (c - 2));
      run_tile(3, 1'b0, 16'h4321, 16'h10FE, 1'b1, 1'b1, 1'b0, -1);

      // 2-bit activation mode, start and in_valid poked while busy
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) exp_m[r][c] = 16'd6;
      run_tile(2, 1'b1, 16'hFFFF, 16'h1111, 1'b0, 1'b0, 1'b1, -1);

      // long reduction overflowing 16 bits
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++)
`ifdef OS_MAC_ARRAY_SATURATE_EN
         exp_m[r][c] = 16'h7FFF;
`else
         exp_m[r][c] = 16'hA410;
`endif
      run_tile(400, 1'b0, 16'hFFFF, 16'h7777, 1'b0, 1'b0, 1'b0, -1);

      // reset during drain at row 2, then an empty tile
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) exp_m[r][c] = 16'd1;
      run_tile(1, 1'b0, 16'h1111, 16'h1111, 1'b0, 1'b0, 1'b0, 2);
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) exp_m[r][c] = 16'd0;
      run_tile(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/os_mac_array.md
OS_MAC_ARRAY -- requirements
Module: os_mac_array

Interface
REQ-001 Parameter BW, 4, activation and weight bit width.
REQ-002 Parameter PSUM_BW, 16, accumulator and output element width.
REQ-003 Parameter ROWS, 8, PE rows; each row has its own activation lane.
REQ-004 Parameter COLS, 8, PE columns; each column has its own weight lane.
REQ-005 Parameter KW, 10, width of k_len.
REQ-006 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1, asynchronous, active-high; clears all state immediately.
REQ-008 Port start, input, 1, begins a tile; sampled only in IDLE.
REQ-009 Port k_len, input, KW, reduction length of the tile; sampled with start.
REQ-010 Port act_2b_mode, input, 1, activations use only bits [1:0]; sampled with start.
REQ-011 Port in_w, input, ROWS*BW, unsigned activations; lane r is bits [r*BW +: BW].
REQ-012 Port in_n, input, COLS*BW, signed weights; lane c is bits [c*BW +: BW].
REQ-013 Port in_valid, input, 1, in_w and in_n hold one reduction step.
REQ-014 Port in_ready, output, 1, the block accepts a step.
REQ-015 Port out_data, output, COLS*PSUM_BW, all accumulators of row out_row.
REQ-016 Port out_row, output, clog2(ROWS), index of the row currently presented.
REQ-017 Port out_valid, output, 1, out_data is valid.
REQ-018 Port out_ready, input, 1, consumer accepts out_data.
REQ-019 Port busy, output, 1, high in every state except IDLE.
REQ-020 Port done, output, 1, one-cycle pulse after the last row is accepted.

Function
REQ-021 The FSM shall have states IDLE, LOAD, SETTLE and DRAIN.
REQ-022 IDLE plus start shall clear all accumulators and latch k_len and act_2b_mode. The FSM goes to LOAD, or to SETTLE if k_len==0.
REQ-023 In LOAD, in_ready=1; the block accepts one step per in_valid&in_ready cycle. After k_len accepted steps it goes to SETTLE.
REQ-024 in_ready shall be 0 outside LOAD. in_valid outside LOAD shall be ignored.
REQ-025 Activation lane r shall pass through r skew registers before column 0 of row r. Weight lane c shall pass through c skew registers before row 0 of column c. A valid bit travels with each operand.
REQ-026 Activations shall move one PE east per cycle and weights one PE south per cycle, each through a register in every PE.
REQ-027 PE(r,c) accumulates only when both incoming operands are valid. acc += zero-extended activation times sign-extended weight, computed at PSUM_BW bits. The result wraps modulo 2^PSUM_BW.
REQ-028 With act_2b_mode latched high, the activation bits [BW-1:2] shall be treated as zero.
REQ-029 SETTLE shall last exactly ROWS+COLS cycles, then go to DRAIN with out_row=0.
REQ-030 In DRAIN, out_valid=1 and out_data shows the accumulators of row out_row, with column c at bits [c*PSUM_BW +: PSUM_BW].
REQ-031 While out_valid&!out_ready, out_data and out_row shall stay stable.
REQ-032 On out_valid&out_ready, out_row increments. When out_row==ROWS-1, the next state is IDLE and done is high for one cycle.
REQ-033 start while busy shall be ignored.
REQ-034 A gap cycle (in_valid=0 in LOAD) shall insert a bubble without corrupting any accumulation.
REQ-035 Accumulators shall hold their values after DRAIN until the next start.

Reset
REQ-036 On reset: FSM=IDLE; all accumulators, skew registers, operand registers and valid bits cleared.
REQ-037 On reset: in_ready=0, out_valid=0, out_row=0, out_data=0, busy=0, done=0.
REQ-038 Reset asserted in any state, including mid-LOAD or mid-DRAIN, shall abort the tile with no done pulse.

Configuration
REQ-039 With macro OS_MAC_ARRAY_SATURATE_EN defined, each accumulation shall saturate to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1].
REQ-040 Without OS_MAC_ARRAY_SATURATE_EN, accumulation shall wrap per REQ-027 and no saturation logic is built.

Verification (ROWS=COLS=4, BW=4, PSUM_BW=16)
REQ-041 k_len=1, all activations 1, all weights 1 -> 4 rows drained, every element 1, done pulses once.
REQ-042 k_len=3, step t: activation lane r=r+1, weight lane c=c-2 -> element(r,c)=3*(r+1)*(c-2), e.g. row 3 = {-24,-12,0,12}.
REQ-043 out_ready low for 5 cycles while out_row=1 -> out_data and out_row constant for those 5 cycles, no row skipped or repeated.
REQ-044 act_2b_mode=1, activations 4'hF, weights 1, k_len=2 -> every element 6.
REQ-045 Weight 7, activation 15, k_len=400 -> every element 16'hA410 (-23536) without the macro, 16'h7FFF with OS_MAC_ARRAY_SATURATE_EN.
REQ-046 Reset during DRAIN at out_row=2 -> next cycle out_valid=0, busy=0, no done; a following tile with k_len=0 drains all zeros.
